// File: rtl/dsp_mac_pkg.sv
// rtl/dsp_mac_pkg.sv - shared types and constants for the DSP dot-product sequencer
//
// Contents:
//   state_t          sequencer states IDLE/CLEAR/RUN/DRAIN/DONE
//   OP_W             multiplier operand width (18)
//   ACC_W            DSP accumulator / P width (48)
//   DSP_LAT_DEFAULT  default operand-to-P latency of the DSP slice
//   OPMODE_ACC       opmode selecting P = P + A*B

package dsp_mac_pkg;

  localparam int OP_W            = 18;
  localparam int ACC_W           = 48;
  localparam int DSP_LAT_DEFAULT = 4;

  // X=M, Z=P, no pre-adder, no post-subtract, carry-in 0
  localparam logic [7:0] OPMODE_ACC = 8'h09;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - sequences an external DSP slice through one dot-product run
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   start, len            run request pulse and number of sample pairs
//   busy                  high whenever the sequencer is not idle
//   s_valid, s_ready      sample stream handshake
//   s_a, s_b              signed operand pair
//   dsp_a, dsp_b          operands to the DSP multiplier
//   dsp_opmode, dsp_rstp  DSP opmode and P-register reset
//   dsp_p, dsp_carryout   DSP accumulator output and carry
//   result, result_valid  captured dot product and its one-cycle strobe
//   carry_flag            sticky carry seen during the run

module dsp_mac_sequencer
  import dsp_mac_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int DSP_LAT = DSP_LAT_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [OP_W-1:0]  s_a,
  input  logic [OP_W-1:0]  s_b,
  output logic [OP_W-1:0]  dsp_a,
  output logic [OP_W-1:0]  dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_rstp,
  input  logic [ACC_W-1:0] dsp_p,
  input  logic             dsp_carryout,
  output logic [ACC_W-1:0] result,
  output logic             result_valid,
  output logic             carry_flag
);

  // Phase counter times the fixed-length CLEAR and DRAIN windows.
  localparam int              PH_W    = (DSP_LAT > 1) ? $clog2(DSP_LAT) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DSP_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] remain;
  logic [PH_W-1:0]  phase;
  logic             phase_last;
  logic             xfer;

  assign phase_last = (phase == PH_LAST);
  assign xfer       = s_ready && s_valid;

  // State register and run datapath
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      remain     <= '0;
      phase      <= '0;
      result     <= '0;
      carry_flag <= 1'b0;
    end else begin
      state <= state_nxt;

      // Restart the phase count on every state change so CLEAR and
      // DRAIN each see a full DSP_LAT window from zero.
      if (state_nxt != state) begin
        phase <= '0;
      end else begin
        phase <= phase + PH_W'(1);
      end

      if (state == ST_IDLE && start) begin
        remain     <= len;
        carry_flag <= 1'b0;
      end

      if (state == ST_RUN && xfer) begin
        remain <= remain - LEN_W'(1);
      end

      if ((state == ST_RUN || state == ST_DRAIN) && dsp_carryout) begin
        carry_flag <= 1'b1;
      end

      // By the last DRAIN cycle the final product has reached P.
      if (state == ST_DRAIN && phase_last) begin
        result <= dsp_p;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (phase_last) state_nxt = (remain != '0) ? ST_RUN : ST_DRAIN;
      end
      ST_RUN: begin
        if (xfer && remain == LEN_W'(1)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (phase_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs; s_ready is decoded from state alone so the upstream
  // handshake never forms a combinational loop through s_valid.
  always_comb begin
    busy         = (state != ST_IDLE);
    s_ready      = (state == ST_RUN);
    result_valid = (state == ST_DONE);
    dsp_opmode   = OPMODE_ACC;
    dsp_rstp     = RST || (state == ST_CLEAR);
    dsp_a        = '0;
    dsp_b        = '0;
    // Bubbles feed zero operands so they add nothing to the sum.
    if (state == ST_RUN && s_valid) begin
      dsp_a = s_a;
      dsp_b = s_b;
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb/tb_dsp_mac_sequencer.sv - scoreboard bench for dsp_mac_sequencer with a DSP slice model

module tb_dsp_mac_sequencer;
  import dsp_mac_pkg::*;

  localparam int LEN_W = 8;
  localparam int LAT   = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [17:0]      s_a = '0;
  logic [17:0]      s_b = '0;
  logic [17:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_rstp;
  logic [47:0]      dsp_p;
  logic             dsp_carryout;
  logic [47:0]      result;
  logic             result_valid;
  logic             carry_flag;

  always #5 CLK = ~CLK;

  dsp_mac_sequencer #(.LEN_W(LEN_W), .DSP_LAT(LAT)) dut (
    .CLK(CLK), .RST(RST), .start(start), .len(len), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_rstp(dsp_rstp),
    .dsp_p(dsp_p), .dsp_carryout(dsp_carryout),
    .result(result), .result_valid(result_valid), .carry_flag(carry_flag)
  );

  // DSP slice model: A/B reg, M reg, M pipe reg, P accumulator -> 4 cycles
  logic signed [17:0] a_r = '0, b_r = '0;
  logic signed [35:0] m_r = '0, m_r2 = '0;
  logic [47:0]        p_r = '0;
  logic               co_r = 1'b0;

  always @(posedge CLK) begin
    a_r  <= dsp_a;
    b_r  <= dsp_b;
    m_r  <= a_r * b_r;
    m_r2 <= m_r;
    if (dsp_rstp) begin
      p_r  <= '0;
      co_r <= 1'b0;
    end else begin
      {co_r, p_r} <= {1'b0, p_r} + {1'b0, {{12{m_r2[35]}}, m_r2}};
    end
  end
  assign dsp_p        = p_r;
  assign dsp_carryout = co_r;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired", nm);
  endtask

  typedef struct {
    logic [47:0] res;
    logic        cy;
    int          st;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Monitor: every result_valid must match the oldest expected entry.
  always @(negedge CLK) begin
    if (!RST && result_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result_valid: got result %0h with no run outstanding", result);
      end else begin
        mon_e = sb.pop_front();
        chk("result", {16'h0, result}, {16'h0, mon_e.res});
        chk("carry_flag", {63'h0, carry_flag}, {63'h0, mon_e.cy});
        chk("latency", 64'(cyc - mon_e.st), 64'(mon_e.lat));
        chk("opmode", {56'h0, dsp_opmode}, 64'h09);
      end
    end
  end

  logic watch_ready = 1'b0;
  logic ready_seen  = 1'b0;
  always @(negedge CLK) begin
    if (watch_ready && s_ready) ready_seen = 1'b1;
  end

  logic [17:0] va [4];
  logic [17:0] vb [4];

  task automatic do_run(input int n, input int gap, input logic [47:0] eres,
                        input logic ecy, input logic extra_start);
    exp_t e;
    int   t;
    len     = LEN_W'(n);
    s_valid = 1'b0;
    @(posedge CLK); #1;
    start = 1'b1;
    e.res = eres;
    e.cy  = ecy;
    e.st  = cyc;
    e.lat = 2 * LAT + n + 1 + gap * ((n > 0) ? n - 1 : 0);
    sb.push_back(e);
    @(posedge CLK); #1;
    start = 1'b0;
    chk("busy_after_start", {63'h0, busy}, 64'h1);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          s_valid = 1'b0;
          @(posedge CLK); #1;
        end
      end
      s_valid = 1'b1;
      s_a     = va[i];
      s_b     = vb[i];
      if (extra_start && i == 1) begin
        start = 1'b1;
        len   = '0;
      end
      t = 0;
      while (!s_ready && t < 64) begin
        @(posedge CLK); #1;
        t++;
      end
      if (t >= 64) begin
        fail_now("ready_timeout");
        break;
      end
      @(posedge CLK); #1;
      start = 1'b0;
    end
    s_valid = 1'b0;
    s_a     = '0;
    s_b     = '0;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge CLK); #1;
      t++;
    end
    if (sb.size() != 0) begin
      fail_now("result_timeout");
      sb.delete();
    end
    repeat (3) @(posedge CLK);
    #1;
    chk("result_hold", {16'h0, result}, {16'h0, eres});
    chk("busy_idle", {63'h0, busy}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;

    // Reset values
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_result", {16'h0, result}, 64'h0);
    chk("rst_result_valid", {63'h0, result_valid}, 64'h0);
    chk("rst_carry_flag", {63'h0, carry_flag}, 64'h0);
    chk("rst_s_ready", {63'h0, s_ready}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_dsp_ab", {28'h0, dsp_a, dsp_b}, 64'h0);
    chk("rst_opmode", {56'h0, dsp_opmode}, 64'h09);
    chk("rst_dsp_rstp", {63'h0, dsp_rstp}, 64'h1);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // (2,3),(4,5),(-1,7): 6+20-7 = 19; the -7 step wraps P and carries
    va[0] = 18'd2;      vb[0] = 18'd3;
    va[1] = 18'd4;      vb[1] = 18'd5;
    va[2] = 18'h3FFFF;  vb[2] = 18'd7;
    do_run(3, 0, 48'h13, 1'b1, 1'b0);

    // Empty run: zero result, carry cleared, stream never ready
    ready_seen  = 1'b0;
    watch_ready = 1'b1;
    do_run(0, 0, 48'h0, 1'b0, 1'b0);
    watch_ready = 1'b0;
    chk("s_ready_never_len0", {63'h0, ready_seen}, 64'h0);

    // -1 * 11 = -11
    va[0] = 18'h3FFFF;  vb[0] = 18'h0000B;
    do_run(1, 0, 48'hFFFF_FFFF_FFF5, 1'b0, 1'b0);

    // Same vector with two idle cycles between pairs
    va[0] = 18'd2;      vb[0] = 18'd3;
    va[1] = 18'd4;      vb[1] = 18'd5;
    va[2] = 18'h3FFFF;  vb[2] = 18'd7;
    do_run(3, 2, 48'h13, 1'b1, 1'b0);

    // Most negative squared twice: 2 * 2^34 = 2^35
    va[0] = 18'h20000;  vb[0] = 18'h20000;
    va[1] = 18'h20000;  vb[1] = 18'h20000;
    do_run(2, 1, 48'h0008_0000_0000, 1'b0, 1'b0);

    // Start pulsed mid-RUN is ignored: 3*4 + 5*6 = 42
    va[0] = 18'd3;      vb[0] = 18'd4;
    va[1] = 18'd5;      vb[1] = 18'd6;
    do_run(2, 0, 48'h2A, 1'b0, 1'b1);

    // Reset in the middle of RUN aborts without a result
    len     = LEN_W'(3);
    @(posedge CLK); #1;
    start = 1'b1;
    @(posedge CLK); #1;
    start   = 1'b0;
    s_valid = 1'b1;
    s_a     = 18'd9;
    s_b     = 18'd9;
    t = 0;
    while (!s_ready && t < 64) begin
      @(posedge CLK); #1;
      t++;
    end
    if (t >= 64) fail_now("abort_ready_timeout");
    @(posedge CLK); #1;
    RST     = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("abort_busy", {63'h0, busy}, 64'h0);
    chk("abort_s_ready", {63'h0, s_ready}, 64'h0);
    chk("abort_result", {16'h0, result}, 64'h0);
    chk("abort_dsp_rstp", {63'h0, dsp_rstp}, 64'h1);
    RST = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    chk("abort_stays_idle", {63'h0, busy}, 64'h0);

    va[0] = 18'd2;      vb[0] = 18'd3;
    va[1] = 18'd4;      vb[1] = 18'd5;
    va[2] = 18'h3FFFF;  vb[2] = 18'd7;
    do_run(3, 0, 48'h13, 1'b1, 1'b0);

    repeat (5) @(posedge CLK);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
